dccm_port_arbiter: RTL and testbench

Two-port arbiter that shares the single-port DCCM SRAM (16384×32, 1-cycle read latency) between the core LSU data port and an external loader/debug port. It sits in `lp_riscv` between the core data interface and `dccm_ram_wrapper`, alongside the program-loading path. It uses fixed core priority with a starvation guard and produces the response strobes. It also emits a per-cycle conflict pulse for the external performance counters.

---
 rtl/dccm_port_arbiter.sv | 112 +++++++++++
 tb/tb_dccm_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dccm_port_arbiter.sv
// Shares the single-port DCCM SRAM between the core LSU port and the external loader/debug port.
// The core has fixed priority, and a starvation guard hands the ext port a slot after STARVE_MAX losses.
module dccm_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [DATA_W/8-1:0] core_be_i,
  input  logic [31:0]         core_addr_i,
  input  logic [DATA_W-1:0]   core_wdata_i,
  output logic                core_gnt_o,
  output logic                core_rvalid_o,
  output logic [DATA_W-1:0]   core_rdata_o,
  input  logic                ext_req_i,
  input  logic                ext_we_i,
  input  logic [DATA_W/8-1:0] ext_be_i,
  input  logic [31:0]         ext_addr_i,
  input  logic [DATA_W-1:0]   ext_wdata_i,
  output logic                ext_gnt_o,
  output logic                ext_rvalid_o,
  output logic [DATA_W-1:0]   ext_rdata_o,
  output logic                sram_ce_o,
  output logic                sram_we_o,
  output logic [DATA_W/8-1:0] sram_be_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_rdata_i,
  output logic                conflict_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic             both_req;
  logic             ext_turn;
  logic             core_grant;
  logic             ext_grant;
  logic [CNT_W-1:0] starve_cnt;
  logic             resp_valid;
  logic             resp_ext;
  logic             conflict;
  logic             unused_addr;

  assign both_req = core_req_i & ext_req_i;
  assign ext_turn = both_req & (starve_cnt == CNT_MAX);

  // Grants are combinational and held off entirely while reset is asserted.
  assign core_grant = ~rst & core_req_i & ~ext_turn;
  assign ext_grant  = ~rst & ext_req_i & (~core_req_i | ext_turn);

  assign core_gnt_o = core_grant;
  assign ext_gnt_o  = ext_grant;

  // Counts consecutive cycles in which the ext port lost to the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!ext_req_i || ext_grant) begin
      starve_cnt <= '0;
    end else if (core_grant && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    sram_ce_o    = core_grant | ext_grant;
    sram_we_o    = 1'b0;
    sram_be_o    = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (core_grant) begin
      sram_we_o    = core_we_i;
      sram_be_o    = core_be_i;
      sram_addr_o  = core_addr_i[ADDR_W+1:2];
      sram_wdata_o = core_wdata_i;
    end else if (ext_grant) begin
      sram_we_o    = ext_we_i;
      sram_be_o    = ext_be_i;
      sram_addr_o  = ext_addr_i[ADDR_W+1:2];
      sram_wdata_o = ext_wdata_i;
    end
  end

  // Remembers which port owns the response that appears on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_ext   <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      resp_valid <= core_grant | ext_grant;
      resp_ext   <= ext_grant;
      conflict   <= both_req;
    end
  end

  // Gating with rst drops a response whose grant was followed directly by reset.
  assign core_rvalid_o = resp_valid & ~resp_ext & ~rst;
  assign ext_rvalid_o  = resp_valid & resp_ext & ~rst;
  assign core_rdata_o  = sram_rdata_i;
  assign ext_rdata_o   = sram_rdata_i;
  assign conflict_o    = conflict;

  assign unused_addr = ^{core_addr_i[31:ADDR_W+2], core_addr_i[1:0],
                         ext_addr_i[31:ADDR_W+2], ext_addr_i[1:0], BE_W[0]};

endmodule

// File: tb/tb_dccm_port_arbiter.sv
// Directed bench for dccm_port_arbiter: a behavioural SRAM, a reference model checked every cycle,
// and literal expectations for the key scenarios.
module tb_dccm_port_arbiter;

  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        core_req, core_we, ext_req, ext_we;
  logic [3:0]  core_be, ext_be;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic        core_gnt, core_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] core_rdata, ext_rdata;
  logic        sram_ce, sram_we;
  logic [3:0]  sram_be;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        conflict;

  int total = 0;
  int bad   = 0;

  dccm_port_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_be_i(ext_be),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata),
    .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_be_o(sram_be),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .conflict_o(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM with a registered read port.
  logic [31:0] sram_mem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) sram_mem[i] = 32'h0;
    sram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: storage contents, ext losing streak, and the response owed next cycle.
  logic [31:0] ref_mem [int];
  int          losses = 0;
  bit          owed = 0, owed_ext = 0, owed_read = 0;
  logic [31:0] owed_data = 0;
  bit          exp_conflict = 0;

  function automatic logic [31:0] ref_read(input int word);
    if (ref_mem.exists(word)) return ref_mem[word];
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    bit          cg, eg, crv, erv;
    int          word;
    logic [31:0] merged;
    cg = 0;
    eg = 0;
    if (!rst) begin
      if (core_req && ext_req) begin
        if (losses >= SMAX) eg = 1; else cg = 1;
      end else begin
        cg = core_req;
        eg = ext_req;
      end
    end
    crv = !rst && owed && !owed_ext;
    erv = !rst && owed && owed_ext;

    checkOutput("core_gnt", {31'b0, core_gnt}, {31'b0, cg});
    checkOutput("ext_gnt", {31'b0, ext_gnt}, {31'b0, eg});
    checkOutput("sram_ce", {31'b0, sram_ce}, {31'b0, cg | eg});
    checkOutput("core_rvalid", {31'b0, core_rvalid}, {31'b0, crv});
    checkOutput("ext_rvalid", {31'b0, ext_rvalid}, {31'b0, erv});
    checkOutput("conflict", {31'b0, conflict}, {31'b0, exp_conflict});
    if (crv && owed_read) checkOutput("core_rdata", core_rdata, owed_data);
    if (erv && owed_read) checkOutput("ext_rdata", ext_rdata, owed_data);
    if (cg || eg) begin
      checkOutput("sram_addr", {18'b0, sram_addr}, cg ? {18'b0, core_addr[15:2]} : {18'b0, ext_addr[15:2]});
      checkOutput("sram_we", {31'b0, sram_we}, {31'b0, cg ? core_we : ext_we});
      checkOutput("sram_be", {28'b0, sram_be}, {28'b0, cg ? core_be : ext_be});
      checkOutput("sram_wdata", sram_wdata, cg ? core_wdata : ext_wdata);
    end

    if (rst) begin
      losses       = 0;
      owed         = 0;
      exp_conflict = 0;
    end else begin
      exp_conflict = core_req && ext_req;
      owed         = cg || eg;
      owed_ext     = eg;
      if (cg || eg) begin
        word      = cg ? int'(core_addr[15:2]) : int'(ext_addr[15:2]);
        owed_read = cg ? !core_we : !ext_we;
        if (owed_read) begin
          owed_data = ref_read(word);
        end else begin
          merged = ref_read(word);
          for (int b = 0; b < 4; b++)
            if (cg ? core_be[b] : ext_be[b])
              merged[b*8 +: 8] = cg ? core_wdata[b*8 +: 8] : ext_wdata[b*8 +: 8];
          ref_mem[word] = merged;
        end
      end
      if (core_req && ext_req && cg) losses = losses + 1;
      else if (!ext_req || eg) losses = 0;
    end
  end

  task automatic applyStimulus(input logic r,
                               input logic cr, input logic cw, input logic [3:0] cb,
                               input logic [31:0] ca, input logic [31:0] cd,
                               input logic er, input logic ew, input logic [3:0] eb,
                               input logic [31:0] ea, input logic [31:0] ed);
    @(posedge clk);
    #1;
    rst = r;
    core_req = cr; core_we = cw; core_be = cb; core_addr = ca; core_wdata = cd;
    ext_req = er; ext_we = ew; ext_be = eb; ext_addr = ea; ext_wdata = ed;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [9:0] gmask;
  logic [4:0] rmask;

  initial begin
    rst = 1;
    core_req = 1; core_we = 0; core_be = 4'hF; core_addr = 32'h0; core_wdata = 32'h0;
    ext_req = 1; ext_we = 0; ext_be = 4'hF; ext_addr = 32'h4; ext_wdata = 32'h0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_gnt", {30'b0, core_gnt, ext_gnt}, 32'h0);
      checkOutput("rst_ce_conf", {30'b0, sram_ce, conflict}, 32'h0);
      checkOutput("rst_rvalid", {30'b0, core_rvalid, ext_rvalid}, 32'h0);
    end

    applyStimulus(0, 1, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0);
    checkOutput("release_core_gnt", {31'b0, core_gnt}, 32'h1);
    idle();

    applyStimulus(0, 1, 1, 4'hF, 32'h00002000, 32'h7C3E1A2A, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("wr_sram_addr", {18'b0, sram_addr}, 32'h0800);
    applyStimulus(0, 1, 0, 4'hF, 32'h00002000, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    checkOutput("wr_rvalid", {31'b0, core_rvalid}, 32'h1);
    idle();
    checkOutput("rd_rvalid", {31'b0, core_rvalid}, 32'h1);
    checkOutput("rd_data", core_rdata, 32'h7C3E1A2A);

    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF, 32'h00000100, 32'hFFFFFFFF);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'b0010, 32'h00000100, 32'h0000AB00);
    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h00000100, 32'h0);
    idle();
    checkOutput("be_rvalid", {31'b0, ext_rvalid}, 32'h1);
    checkOutput("be_data", ext_rdata, 32'hFFFFABFF);

    gmask = '0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 4'hF, 32'h00002000, 32'h0, 1, 0, 4'hF, 32'h00000100, 32'h0);
      gmask[i] = ext_gnt;
      if (i > 0) checkOutput("starve_conflict", {31'b0, conflict}, 32'h1);
    end
    checkOutput("starve_grants", {22'b0, gmask}, 32'h210);
    idle();
    checkOutput("conflict_tail", {31'b0, conflict}, 32'h1);
    checkOutput("last_ext_rvalid", {31'b0, ext_rvalid}, 32'h1);
    idle();
    checkOutput("conflict_drop", {31'b0, conflict}, 32'h0);

    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF, 32'h00012000, 32'h12345678);
    applyStimulus(0, 1, 0, 4'hF, 32'h00002000, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    idle();
    checkOutput("alias_data", core_rdata, 32'h12345678);

    applyStimulus(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF, 32'h00000300, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 4'hF, 32'h00000300, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    idle();
    checkOutput("cross_port_data", core_rdata, 32'hDEADBEEF);

    applyStimulus(0, 1, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0);
    applyStimulus(0, 1, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0);
    applyStimulus(0, 1, 0, 4'hF, 32'h00002000, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0);
    checkOutput("midrst_core_gnt", {31'b0, core_gnt}, 32'h1);
    applyStimulus(1, 1, 0, 4'hF, 32'h00002000, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0);
    checkOutput("midrst_no_rvalid", {31'b0, core_rvalid}, 32'h0);
    rmask = '0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 4'hF, 32'h0, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0);
      rmask[i] = ext_gnt;
    end
    checkOutput("midrst_streak_cleared", {27'b0, rmask}, 32'h10);
    idle();
    idle();

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
